// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
// Sequencing controller for the HI/LO multiply/divide unit of the five-stage
// pipeline. It accepts mult/multu/div/divu/mthi/mtlo from the Execute stage
// and holds multiply and divide busy for a fixed number of cycles. It also
// owns the architectural HI/LO registers and raises a stall request for
// Decode-stage HI/LO instructions.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu   (1..15)
//
// Optional feature macro:
//   MUL_DIV_DIV0_FAST_EN  when defined, a divide by zero stays busy for 1 cycle
//
// Ports:
//   clk        pipeline clock, rising-edge
//   reset      asynchronous active-low reset
//   E_MDOp     E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//              5 mthi, 6 mtlo, 7 reserved (none)
//   E_start    qualifies E_MDOp
//   E_A, E_B   rs / rt operands
//   D_isMD     Decode holds a HI/LO instruction
//   busy       multiply/divide in progress (registered)
//   stall_req  freeze F/D, insert E bubble (combinational)
//   HI, LO     architectural HI/LO registers
//   done       one-cycle pulse after a mult/div commit
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MDOp,
    input  logic        E_start,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_isMD,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // The counter is loaded with N-1 so the commit edge is exactly N edges
    // after the start edge.
    localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_signed;

    // Datapath, evaluated from the latched operands only.
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // A multiply/divide starting this cycle from Execute.
    logic        md_start;

    assign md_start  = E_start && (E_MDOp >= OP_MULT) && (E_MDOp <= OP_DIVU);
    assign stall_req = D_isMD & (busy | md_start);

    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        a_ext    = '0;
        b_ext    = '0;
        product  = '0;
        a_neg    = 1'b0;
        b_neg    = 1'b0;
        a_mag    = '0;
        b_mag    = '1;
        div_zero = 1'b0;
        q_mag    = '0;
        r_mag    = '0;
        quot     = '0;
        rem      = '0;

        // Signed/unsigned multiply by extending both operands to 64 bits.
        a_ext   = op_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
        b_ext   = op_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
        product = a_ext * b_ext;

        // Signed divide done on magnitudes: this truncates toward zero and
        // makes 0x80000000 / -1 wrap to 0x80000000 without a special case.
        a_neg    = op_signed & op_a[31];
        b_neg    = op_signed & op_b[31];
        a_mag    = a_neg ? (32'd0 - op_a) : op_a;
        div_zero = (op_b == 32'd0);
        if (!div_zero) begin
            b_mag = b_neg ? (32'd0 - op_b) : op_b;
        end
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem   = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (E_start) begin
                        case (E_MDOp)
                            OP_MULT, OP_MULTU: begin
                                op_a      <= E_A;
                                op_b      <= E_B;
                                op_signed <= (E_MDOp == OP_MULT);
                                cnt       <= MUL_LOAD;
                                state     <= ST_MUL;
                                busy      <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_a      <= E_A;
                                op_b      <= E_B;
                                op_signed <= (E_MDOp == OP_DIV);
`ifdef MUL_DIV_DIV0_FAST_EN
                                cnt       <= (E_B == 32'd0) ? 4'd0 : DIV_LOAD;
`else
                                cnt       <= DIV_LOAD;
`endif
                                state     <= ST_DIV;
                                busy      <= 1'b1;
                            end
                            OP_MTHI: HI <= E_A;
                            OP_MTLO: LO <= E_A;
                            default: ;
                        endcase
                    end
                end

                ST_MUL, ST_DIV: begin
                    // Starts arriving while busy are ignored here.
                    if (cnt == 4'd0) begin
                        if (state == ST_MUL) begin
                            HI <= product[63:32];
                            LO <= product[31:0];
                        end else if (!div_zero) begin
                            HI <= rem;
                            LO <= quot;
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
